// File: rtl/sram_nw1r_lvt.sv
// sram_nw1r_lvt: NUM_W-write/1-read memory from per-port banks selected by a live-value table
module dpsram #(
  parameter int W = 32,
  parameter int N = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              en0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [W-1:0]      din0,
  input  logic              en1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [W-1:0]      dout1
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk) begin
    if (en0) mem[addr0] <= din0;
    if (en1) dout1 <= mem[addr1];
  end
endmodule

module sram_nw1r_lvt #(
  parameter int NUM_W = 2,
  parameter int W = 32,
  parameter int N = 8,
  localparam int ADDR_W = $clog2(N),
  localparam int SEL_W = $clog2(NUM_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_W-1:0]        wen,
  input  logic [NUM_W*ADDR_W-1:0] waddr,
  input  logic [NUM_W*W-1:0]      wdata,
  input  logic                    ren,
  input  logic [ADDR_W-1:0]       raddr,
  output logic                    rvalid,
  output logic [W-1:0]            rdata
);
  localparam logic [ADDR_W:0] NL = (ADDR_W+1)'(N);
  logic [ADDR_W-1:0] wa [NUM_W];
  logic [NUM_W-1:0]  wv;
  logic [W-1:0]      dout [2**SEL_W];
  logic [SEL_W-1:0]  lvt [N];
  logic [SEL_W-1:0]  sel_q;
  logic              hit, hit_q;
  logic [W-1:0]      byp, byp_q;
  genvar g;
  for (g = 0; g < 2**SEL_W; g++) begin : g_bank
    if (g < NUM_W) begin : g_on
      assign wa[g] = waddr[g*ADDR_W +: ADDR_W];
      assign wv[g] = wen[g] && ({1'b0, wa[g]} < NL);
      dpsram #(.W(W), .N(N), .ADDR_W(ADDR_W)) u_bank (
        .clk(clk), .en0(wv[g]), .addr0(wa[g]), .din0(wdata[g*W +: W]),
        .en1(ren), .addr1(raddr), .dout1(dout[g])
      );
    end else begin : g_off
      assign dout[g] = '0;
    end
  end
  // Write-first bypass: the highest-index port hitting raddr supplies the data
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int i = 0; i < NUM_W; i++)
      if (wv[i] && wa[i] == raddr) begin
        hit = ren;
        byp = wdata[i*W +: W];
      end
  end
  // Later loop iterations override earlier ones, so the highest port owns the entry
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int e = 0; e < N; e++) lvt[e] <= '0;
      rvalid <= 1'b0;
      sel_q <= '0;
      hit_q <= 1'b0;
      byp_q <= '0;
    end else begin
      for (int i = 0; i < NUM_W; i++) if (wv[i]) lvt[wa[i]] <= SEL_W'(i);
      rvalid <= ren;
      if (ren) begin
        sel_q <= ({1'b0, raddr} < NL) ? lvt[raddr] : '0;
        hit_q <= hit;
        byp_q <= byp;
      end
    end
  assign rdata = !rvalid ? '0 : hit_q ? byp_q : dout[sel_q];
endmodule

// File: tb/tb_sram_nw1r_lvt.sv
// tb_sram_nw1r_lvt: randomized self-checking bench against a latest-value memory model
module tb_sram_nw1r_lvt;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  wen = '0;
  logic [5:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic        ren = 1'b0;
  logic [2:0]  raddr = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] lat [8];
  logic        exp_v;
  logic [31:0] exp_d;
  int          n_tests = 0;
  int          n_fail = 0;

  sram_nw1r_lvt dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rvalid(rvalid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model applies writes in port order before the read (write-first)
  task automatic cyc(input logic [1:0] we, input logic [2:0] a0, input logic [31:0] d0,
                     input logic [2:0] a1, input logic [31:0] d1, input logic r, input logic [2:0] ra);
    wen = we; waddr = {a1, a0}; wdata = {d1, d0}; ren = r; raddr = ra;
    if (we[0]) lat[a0] = d0;
    if (we[1]) lat[a1] = d1;
    exp_v = r;
    exp_d = r ? lat[ra] : 32'h0;
    @(posedge clk); #1;
    wen = '0; ren = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_tests++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: rvalid=%0b rdata=%h expected 0 00000000", rvalid, rdata);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    cyc(2'b01, 3'd3, 32'hA5A5_0003, 3'd0, 32'h0, 1'b0, 3'd0);
    n_tests++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL idle: rvalid=%0b rdata=%h expected 0 00000000", rvalid, rdata);
    end
    cyc(2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 1'b1, 3'd3);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 32'hA5A5_0003) begin
      n_fail++;
      $display("FAIL basic: rvalid=%0b rdata=%h expected 1 a5a50003", rvalid, rdata);
    end
  endtask

  task automatic test_overwrite;
    cyc(2'b01, 3'd5, 32'h11, 3'd0, 32'h0, 1'b0, 3'd0);
    cyc(2'b10, 3'd0, 32'h0, 3'd5, 32'h22, 1'b0, 3'd0);
    cyc(2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 1'b1, 3'd5);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h22) begin
      n_fail++;
      $display("FAIL overwrite_p1: rvalid=%0b rdata=%h expected 1 00000022", rvalid, rdata);
    end
    cyc(2'b01, 3'd5, 32'h33, 3'd0, 32'h0, 1'b0, 3'd0);
    cyc(2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 1'b1, 3'd5);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h33) begin
      n_fail++;
      $display("FAIL overwrite_p0: rvalid=%0b rdata=%h expected 1 00000033", rvalid, rdata);
    end
  endtask

  task automatic test_conflict;
    cyc(2'b11, 3'd2, 32'hAA, 3'd2, 32'hBB, 1'b0, 3'd0);
    cyc(2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 1'b1, 3'd2);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 32'hBB) begin
      n_fail++;
      $display("FAIL conflict: rvalid=%0b rdata=%h expected 1 000000bb", rvalid, rdata);
    end
  endtask

  task automatic test_collision;
    cyc(2'b01, 3'd7, 32'h1, 3'd0, 32'h0, 1'b0, 3'd0);
    cyc(2'b10, 3'd0, 32'h0, 3'd7, 32'hDEAD_BEEF, 1'b1, 3'd7);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL collision: rvalid=%0b rdata=%h expected 1 deadbeef", rvalid, rdata);
    end
    cyc(2'b11, 3'd6, 32'h1234_5678, 3'd6, 32'h8765_4321, 1'b1, 3'd6);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h8765_4321) begin
      n_fail++;
      $display("FAIL collision_both: rvalid=%0b rdata=%h expected 1 87654321", rvalid, rdata);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 8; i++)
      if (i % 2 == 0) cyc(2'b01, 3'(i), $urandom, 3'd0, 32'h0, 1'b0, 3'd0);
      else            cyc(2'b10, 3'd0, 32'h0, 3'(i), $urandom, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 1'b1, 3'(i));
      n_tests++;
      if (rvalid !== 1'b1 || rdata !== exp_d) begin
        n_fail++;
        $display("FAIL stream[%0d]: rvalid=%0b rdata=%h expected 1 %h", i, rvalid, rdata, exp_d);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      cyc(2'($urandom), 3'($urandom), $urandom, 3'($urandom), $urandom, 1'($urandom), 3'($urandom));
      n_tests++;
      if (rvalid !== exp_v || rdata !== exp_d) begin
        n_fail++;
        $display("FAIL random[%0d]: rvalid=%0b rdata=%h expected %0b %h", i, rvalid, rdata, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d1;
    d1 = 32'h5A5A_0004;
    cyc(2'b01, 3'd4, 32'h0404_0404, 3'd0, 32'h0, 1'b0, 3'd0);
    cyc(2'b10, 3'd0, 32'h0, 3'd4, d1, 1'b0, 3'd0);
    cyc(2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 1'b1, 3'd4);
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== d1) begin
      n_fail++;
      $display("FAIL pre_reset_read: rvalid=%0b rdata=%h expected 1 %h", rvalid, rdata, d1);
    end
    ren = 1'b1; raddr = 3'd4;
    rst = 1'b0;
    #1;
    n_tests++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: rvalid=%0b rdata=%h expected 0 00000000", rvalid, rdata);
    end
    @(negedge clk);
    ren = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_discard: rvalid=%0b rdata=%h expected 0 00000000", rvalid, rdata);
    end
    cyc(2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 1'b1, 3'd4);
    n_tests++;
    if (rvalid !== 1'b1 || rdata === d1) begin
      n_fail++;
      $display("FAIL lvt_cleared: rvalid=%0b rdata=%h required rvalid 1 and not %h", rvalid, rdata, d1);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) lat[i] = 32'h0;
    test_reset;
    test_basic;
    test_overwrite;
    test_conflict;
    test_collision;
    test_stream;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
